// File: rtl/debug_ctrl_dump.sv
// rtl/debug_ctrl_dump.sv - host debug controller: program load, run/step control, register dump
//
// Purpose:
//   Sits between the UART word assembler/serialiser and the CPU top. Receives
//   32-bit command/data words, loads a program into instruction memory, runs
//   the CPU continuously or one cycle at a time, and after every run or step
//   streams PC followed by NUM_REGS register values back to the host.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-high reset
//   i_rx_valid, i_rx_data    received word (one-cycle pulse)
//   i_halt                   CPU retired the halt word (level)
//   i_pc                     current CPU PC
//   i_reg_data               register file read data for o_reg_addr (same cycle)
//   i_tx_ready               transmitter accepts o_tx_data
//   o_imem_we/addr/wdata     instruction memory write port
//   o_cpu_en                 CPU clock enable
//   o_cpu_rst                CPU/pipeline reset request
//   o_reg_addr               register file debug read address
//   o_tx_valid, o_tx_data    word to transmit, held until accepted
//   o_prog_ready             a complete program is loaded
//   o_load_err               last load overflowed the instruction memory
//   o_mode                   current FSM state encoding

module debug_ctrl_dump #(
    parameter int IMEM_DEPTH = 256,
    parameter int NUM_REGS   = 32,
    localparam int AW = $clog2(IMEM_DEPTH),
    localparam int RW = $clog2(NUM_REGS)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_rx_valid,
    input  logic [31:0]   i_rx_data,
    input  logic          i_halt,
    input  logic [31:0]   i_pc,
    input  logic [31:0]   i_reg_data,
    input  logic          i_tx_ready,
    output logic          o_imem_we,
    output logic [AW-1:0] o_imem_addr,
    output logic [31:0]   o_imem_wdata,
    output logic          o_cpu_en,
    output logic          o_cpu_rst,
    output logic [RW-1:0] o_reg_addr,
    output logic          o_tx_valid,
    output logic [31:0]   o_tx_data,
    output logic          o_prog_ready,
    output logic          o_load_err,
    output logic [2:0]    o_mode
);

    localparam logic [31:0] CMD_CHM  = 32'h0063_686D;
    localparam logic [31:0] CMD_COM  = 32'h0063_6F6D;
    localparam logic [31:0] CMD_STM  = 32'h0073_746D;
    localparam logic [31:0] CMD_NXT  = 32'h006E_7874;
    localparam logic [31:0] CMD_CLST = 32'h636C_7374;
    localparam logic [31:0] CMD_END  = 32'hFFFF_FFFF;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_LOAD      = 3'd1;
    localparam logic [2:0] ST_RUN       = 3'd2;
    localparam logic [2:0] ST_STEP_WAIT = 3'd3;
    localparam logic [2:0] ST_STEP_EXEC = 3'd4;
    localparam logic [2:0] ST_DUMP      = 3'd5;

    // Counter is one bit wider than the address so it can reach IMEM_DEPTH,
    // which is the "memory full" marker.
    localparam logic [AW:0] DEPTH_FULL = (AW + 1)'(IMEM_DEPTH);
    // Slot 0 is the PC, slots 1..NUM_REGS are registers 0..NUM_REGS-1.
    localparam logic [RW:0] LAST_SLOT  = (RW + 1)'(NUM_REGS);
    localparam logic [RW:0] SLOT_ONE   = (RW + 1)'(1);

    logic [2:0]  state;
    logic [AW:0] wr_cnt;
    logic [RW:0] dump_slot;
    logic        dump_fetch;   // first cycle of a slot: capture the word
    logic        from_step;    // dump was started by NXT, may return to STEP_WAIT

    assign o_mode    = state;
    assign o_cpu_rst = (state == ST_LOAD);
    // Halt drops the enable in the same cycle so the CPU never runs past it.
    assign o_cpu_en  = ((state == ST_RUN) && !i_halt) || (state == ST_STEP_EXEC);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_IDLE;
            wr_cnt       <= '0;
            dump_slot    <= '0;
            dump_fetch   <= 1'b1;
            from_step    <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_reg_addr   <= '0;
            o_tx_valid   <= 1'b0;
            o_tx_data    <= '0;
            o_prog_ready <= 1'b0;
            o_load_err   <= 1'b0;
        end else begin
            o_imem_we <= 1'b0;

            // Outside DUMP keep the slot walker parked at the PC slot, so
            // every entry into DUMP starts a fresh report.
            if (state != ST_DUMP) begin
                dump_slot  <= '0;
                dump_fetch <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_CHM) begin
                            state        <= ST_LOAD;
                            o_prog_ready <= 1'b0;
                            o_load_err   <= 1'b0;
                            wr_cnt       <= '0;
                        end else if (i_rx_data == CMD_COM && o_prog_ready) begin
                            state <= ST_RUN;
                        end else if (i_rx_data == CMD_STM && o_prog_ready) begin
                            state <= ST_STEP_WAIT;
                        end
                    end
                end

                ST_LOAD: begin
                    if (i_rx_valid) begin
                        if (wr_cnt == DEPTH_FULL) begin
                            o_load_err   <= 1'b1;
                            o_prog_ready <= 1'b0;
                            state        <= ST_IDLE;
                        end else begin
                            // END is stored too: it is the CPU's halt word.
                            o_imem_we    <= 1'b1;
                            o_imem_addr  <= wr_cnt[AW-1:0];
                            o_imem_wdata <= i_rx_data;
                            wr_cnt       <= wr_cnt + (AW + 1)'(1);
                            if (i_rx_data == CMD_END) begin
                                o_prog_ready <= 1'b1;
                                state        <= ST_IDLE;
                            end
                        end
                    end
                end

                ST_RUN: begin
                    if (i_halt) begin
                        from_step <= 1'b0;
                        state     <= ST_DUMP;
                    end
                end

                ST_STEP_WAIT: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_NXT) begin
                            from_step <= 1'b1;
                            // Already halted: report without clocking the CPU.
                            state     <= i_halt ? ST_DUMP : ST_STEP_EXEC;
                        end else if (i_rx_data == CMD_CLST) begin
                            state <= ST_IDLE;
                        end
                    end
                end

                ST_STEP_EXEC: begin
                    from_step <= 1'b1;
                    state     <= ST_DUMP;
                end

                ST_DUMP: begin
                    if (dump_fetch) begin
                        o_tx_data  <= (dump_slot == '0) ? i_pc : i_reg_data;
                        o_tx_valid <= 1'b1;
                        dump_fetch <= 1'b0;
                    end else if (o_tx_valid && i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        if (dump_slot == LAST_SLOT) begin
                            // CPU is frozen during DUMP, so i_halt here is
                            // the state left behind by the step.
                            state <= (from_step && !i_halt) ? ST_STEP_WAIT : ST_IDLE;
                        end else begin
                            // Next slot k+1 reads register k.
                            o_reg_addr <= dump_slot[RW-1:0];
                            dump_slot  <= dump_slot + SLOT_ONE;
                            dump_fetch <= 1'b1;
                        end
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_debug_ctrl_dump.sv
// tb/tb_debug_ctrl_dump.sv - self-checking bench for debug_ctrl_dump

module tb_debug_ctrl_dump;

    localparam int DEPTH = 4;
    localparam int NREGS = 32;

    localparam logic [31:0] CHM  = 32'h0063_686D;
    localparam logic [31:0] COM  = 32'h0063_6F6D;
    localparam logic [31:0] STM  = 32'h0073_746D;
    localparam logic [31:0] NXT  = 32'h006E_7874;
    localparam logic [31:0] CLST = 32'h636C_7374;
    localparam logic [31:0] ENDW = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_rx_valid = 1'b0;
    logic [31:0] i_rx_data = '0;
    logic        i_halt;
    logic [31:0] i_pc;
    logic [31:0] i_reg_data;
    logic        i_tx_ready = 1'b1;
    logic        o_imem_we;
    logic [1:0]  o_imem_addr;
    logic [31:0] o_imem_wdata;
    logic        o_cpu_en;
    logic        o_cpu_rst;
    logic [4:0]  o_reg_addr;
    logic        o_tx_valid;
    logic [31:0] o_tx_data;
    logic        o_prog_ready;
    logic        o_load_err;
    logic [2:0]  o_mode;

    debug_ctrl_dump #(.IMEM_DEPTH(DEPTH), .NUM_REGS(NREGS)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
        .i_halt(i_halt), .i_pc(i_pc), .i_reg_data(i_reg_data),
        .i_tx_ready(i_tx_ready),
        .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr), .o_imem_wdata(o_imem_wdata),
        .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst), .o_reg_addr(o_reg_addr),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
        .o_prog_ready(o_prog_ready), .o_load_err(o_load_err), .o_mode(o_mode)
    );

    always #5 i_clk = ~i_clk;

    // Abstract CPU: PC counts enabled cycles, halts when it reaches halt_at.
    int cpu_pc = 0;
    int halt_at = 1000;
    always @(posedge i_clk) begin
        if (o_cpu_rst)     cpu_pc <= 0;
        else if (o_cpu_en) cpu_pc <= cpu_pc + 1;
    end
    assign i_halt     = (cpu_pc >= halt_at);
    assign i_pc       = 32'h0000_1000 + 32'(4 * cpu_pc);
    assign i_reg_data = 32'hC0DE_0000 ^ ({27'd0, o_reg_addr} << 16) ^ 32'(cpu_pc);

    function automatic logic [31:0] exp_reg(int r, int pc);
        return 32'hC0DE_0000 ^ (32'(r) << 16) ^ 32'(pc);
    endfunction

    int checks = 0;
    int errors = 0;
    int en_cycles = 0;
    int en_pulses = 0;
    logic prev_en = 1'b0;
    logic prev_hold = 1'b0;
    logic [31:0] prev_data = '0;
    logic rand_ready = 1'b0;
    logic [31:0] exp_tx[$];
    logic [31:0] exp_wa[$];
    logic [31:0] exp_wd[$];
    logic [31:0] tx_log[$];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(logic [31:0] w);
        i_rx_valid = 1'b1;
        i_rx_data  = w;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic push_wr(int a, logic [31:0] d);
        exp_wa.push_back(32'(a));
        exp_wd.push_back(d);
    endtask

    task automatic push_dump(int pc);
        exp_tx.push_back(32'h0000_1000 + 32'(4 * pc));
        for (int r = 0; r < NREGS; r++) exp_tx.push_back(exp_reg(r, pc));
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while ((exp_tx.size() != 0 || o_tx_valid) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: timeout with %0d words outstanding, required 0", name, exp_tx.size());
        end
    endtask

    initial forever begin
        @(posedge i_clk);
        #1;
        i_tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Compare process: checks every observable transfer against the model queues.
    always @(negedge i_clk) begin
        if (i_reset) begin
            prev_hold = 1'b0;
            prev_en   = 1'b0;
        end else begin
            if (o_cpu_en) en_cycles++;
            if (o_cpu_en && !prev_en) en_pulses++;
            prev_en = o_cpu_en;
            if (prev_hold) begin
                chk("tx_valid_held", 32'(o_tx_valid), 32'd1);
                chk("tx_data_held", o_tx_data, prev_data);
            end
            if (o_cpu_en && (o_tx_valid || o_cpu_rst)) begin
                checks++;
                errors++;
                $display("FAIL cpu_en_exclusive: got en=1 tx_valid=%b cpu_rst=%b required en=0", o_tx_valid, o_cpu_rst);
            end
            if (o_imem_we) begin
                if (exp_wd.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0d data %h required no write", o_imem_addr, o_imem_wdata);
                end else begin
                    chk("imem_addr", 32'(o_imem_addr), exp_wa.pop_front());
                    chk("imem_wdata", o_imem_wdata, exp_wd.pop_front());
                end
            end
            if (o_tx_valid && i_tx_ready) begin
                tx_log.push_back(o_tx_data);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_tx: got %h required no word", o_tx_data);
                end else begin
                    chk("tx_word", o_tx_data, exp_tx.pop_front());
                end
            end
            prev_hold = o_tx_valid && !i_tx_ready;
            prev_data = o_tx_data;
        end
    end

    initial begin
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_imem_we", 32'(o_imem_we), 0);
        chk("rst_imem_addr", 32'(o_imem_addr), 0);
        chk("rst_imem_wdata", o_imem_wdata, 0);
        chk("rst_cpu_en", 32'(o_cpu_en), 0);
        chk("rst_cpu_rst", 32'(o_cpu_rst), 0);
        chk("rst_reg_addr", 32'(o_reg_addr), 0);
        chk("rst_tx_valid", 32'(o_tx_valid), 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_prog_ready", 32'(o_prog_ready), 0);
        chk("rst_load_err", 32'(o_load_err), 0);
        chk("rst_mode", 32'(o_mode), 0);
        i_reset = 1'b0;

        // COM without a program is dropped.
        send(COM);
        repeat (3) tick();
        chk("com_no_prog_mode", 32'(o_mode), 0);
        chk("com_no_prog_en", 32'(en_cycles), 0);

        // Load 3 words + END: fills the 4-deep memory exactly.
        push_wr(0, 32'h1111_0000);
        push_wr(1, 32'h2222_0001);
        push_wr(2, 32'h3333_0002);
        push_wr(3, ENDW);
        send(CHM);
        chk("load_cpu_rst", 32'(o_cpu_rst), 1);
        send(32'h1111_0000);
        send(32'h2222_0001);
        send(32'h3333_0002);
        send(ENDW);
        tick();
        chk("load_prog_ready", 32'(o_prog_ready), 1);
        chk("load_err_clear", 32'(o_load_err), 0);
        chk("load_writes_done", 32'(exp_wd.size()), 0);
        chk("load_cpu_rst_off", 32'(o_cpu_rst), 0);

        // Continuous run halting after 10 cycles; COM during DUMP is dropped.
        halt_at = 10;
        en_cycles = 0;
        tx_log.delete();
        push_dump(10);
        send(COM);
        for (int n = 0; n < 100 && !o_tx_valid; n++) tick();
        send(COM);
        wait_drain("run_dump", 1000);
        repeat (5) tick();
        chk("run_en_cycles", 32'(en_cycles), 10);
        chk("run_mode_idle", 32'(o_mode), 0);
        chk("run_log_len", 32'(tx_log.size()), 33);
        chk("run_pc_word", tx_log[0], 32'h0000_1028);
        chk("run_reg5_word", tx_log[6], 32'hC0DB_000A);

        // Reload (resets the CPU), then two single steps with random ready.
        push_wr(0, 32'hABCD_0000);
        push_wr(1, ENDW);
        send(CHM);
        send(32'hABCD_0000);
        send(ENDW);
        tick();
        chk("reload_prog_ready", 32'(o_prog_ready), 1);
        halt_at = 100;
        en_cycles = 0;
        en_pulses = 0;
        rand_ready = 1'b1;
        send(STM);
        repeat (2) tick();
        chk("step_wait_frozen", 32'(en_cycles), 0);
        push_dump(1);
        send(NXT);
        wait_drain("step1_dump", 2000);
        push_dump(2);
        send(NXT);
        wait_drain("step2_dump", 2000);
        rand_ready = 1'b0;
        chk("step_en_cycles", 32'(en_cycles), 2);
        chk("step_en_pulses", 32'(en_pulses), 2);
        send(CLST);
        tick();
        chk("step_clst_idle", 32'(o_mode), 0);

        // STM then CLST: no step at all.
        en_cycles = 0;
        send(STM);
        send(CLST);
        repeat (2) tick();
        chk("stm_clst_idle", 32'(o_mode), 0);
        chk("stm_clst_no_en", 32'(en_cycles), 0);

        // NXT while already halted: dump without stepping, back to IDLE.
        halt_at = 2;
        push_dump(2);
        send(STM);
        send(NXT);
        wait_drain("halted_nxt_dump", 1000);
        tick();
        chk("halted_nxt_no_en", 32'(en_cycles), 0);
        chk("halted_nxt_idle", 32'(o_mode), 0);

        // Reset in the middle of a dump.
        push_dump(2);
        send(COM);
        for (int n = 0; n < 200 && exp_tx.size() > 28; n++) tick();
        i_reset = 1'b1;
        tick();
        chk("mid_rst_tx_valid", 32'(o_tx_valid), 0);
        chk("mid_rst_mode", 32'(o_mode), 0);
        chk("mid_rst_prog_ready", 32'(o_prog_ready), 0);
        i_reset = 1'b0;
        exp_tx.delete();
        tick();

        // Overflow: 5 data words into a 4-deep memory.
        push_wr(0, 32'hB000_0000);
        push_wr(1, 32'hB000_0001);
        push_wr(2, 32'hB000_0002);
        push_wr(3, 32'hB000_0003);
        send(CHM);
        for (int i = 0; i < 5; i++) send(32'hB000_0000 + 32'(i));
        tick();
        chk("ovf_load_err", 32'(o_load_err), 1);
        chk("ovf_prog_ready", 32'(o_prog_ready), 0);
        chk("ovf_mode_idle", 32'(o_mode), 0);
        chk("ovf_writes_done", 32'(exp_wd.size()), 0);
        en_cycles = 0;
        send(COM);
        repeat (4) tick();
        chk("ovf_com_no_en", 32'(en_cycles), 0);
        chk("ovf_com_idle", 32'(o_mode), 0);

        // A new load command clears the sticky error.
        send(CHM);
        chk("chm_clears_err", 32'(o_load_err), 0);
        push_wr(0, ENDW);
        send(ENDW);
        tick();
        chk("end_only_prog_ready", 32'(o_prog_ready), 1);
        chk("end_only_writes_done", 32'(exp_wd.size()), 0);
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
